ctrl_decode_stage: RTL and testbench

CTRL_DECODE_STAGE -- requirements
Module: ctrl_decode_stage

---
 rtl/ctrl_pkg.sv | 42 ++++
 rtl/ctrl_decode_comb.sv | 65 ++++++
 rtl/ctrl_decode_stage.sv | 122 ++++++++++++
 tb/tb_ctrl_decode_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared opcode / ALU-op constants, FSM state encoding and the control bundle
// carried from decode into the stage output register.
package ctrl_pkg;

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_BEQ  = 5'b01001;
  localparam logic [4:0] OP_RAND = 5'b01010;
  localparam logic [4:0] OP_LED  = 5'b01011;
  localparam logic [4:0] OP_CAP  = 5'b01100;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_MD    = 2'd2;

  typedef struct packed {
    logic illegal;
    logic cap;
    logic led_we;
    logic jal;
    logic jr;
    logic j;
    logic rwd;
    logic aluinb;
    logic dmwe;
    logic br;
    logic rwe;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode_comb.sv
// Pure combinational instruction decode: opcode/alu_op/rd -> control bundle,
// plus a flag marking multi-cycle mul/div R-type operations.
module ctrl_decode_comb
  import ctrl_pkg::*;
#(
  parameter int CUSTOM_EN = 1
) (
  input  logic [4:0] opcode_i,
  input  logic [4:0] alu_op_i,
  input  logic [4:0] rd_i,
  output ctrl_t      ctrl_o,
  output logic       is_md_o
);

  logic wr_rd;
  logic custom_ok;

  assign custom_ok = (CUSTOM_EN != 0);

  always_comb begin
    ctrl_o  = '0;
    is_md_o = 1'b0;
    wr_rd   = 1'b0;
    case (opcode_i)
      OP_R: begin
        if (alu_op_i <= ALU_DIV) begin
          wr_rd   = 1'b1;
          is_md_o = (alu_op_i == ALU_MUL) || (alu_op_i == ALU_DIV);
        end else begin
          ctrl_o.illegal = 1'b1;
        end
      end
      OP_J:              ctrl_o.j = 1'b1;
      OP_BNE, OP_BLT,
      OP_BEX:            ctrl_o.br = 1'b1;
      OP_JAL: begin
        ctrl_o.jal = 1'b1;
        ctrl_o.rwe = 1'b1;
      end
      OP_JR:             ctrl_o.jr = 1'b1;
      OP_ADDI: begin
        wr_rd         = 1'b1;
        ctrl_o.aluinb = 1'b1;
      end
      OP_SW: begin
        ctrl_o.dmwe   = 1'b1;
        ctrl_o.aluinb = 1'b1;
      end
      OP_LW: begin
        wr_rd         = 1'b1;
        ctrl_o.aluinb = 1'b1;
        ctrl_o.rwd    = 1'b1;
      end
      OP_BEQ:  if (custom_ok) ctrl_o.br     = 1'b1; else ctrl_o.illegal = 1'b1;
      OP_RAND: if (custom_ok) wr_rd         = 1'b1; else ctrl_o.illegal = 1'b1;
      OP_LED:  if (custom_ok) ctrl_o.led_we = 1'b1; else ctrl_o.illegal = 1'b1;
      OP_CAP:  if (custom_ok) ctrl_o.cap    = 1'b1; else ctrl_o.illegal = 1'b1;
      OP_SETX:           ctrl_o.rwe = 1'b1;
      default:           ctrl_o.illegal = 1'b1;
    endcase
    // Writes to r0 are architecturally dropped, except jal/setx which target fixed regs.
    if (wr_rd && (rd_i != 5'd0)) ctrl_o.rwe = 1'b1;
  end

endmodule

// File: rtl/ctrl_decode_stage.sv
// Decode pipeline stage: single-entry holding register with valid/ready
// handshakes and a fixed-latency occupancy window for mul/div.
module ctrl_decode_stage
  import ctrl_pkg::*;
#(
  parameter int MULDIV_CYC = 32,
  parameter int CUSTOM_EN  = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] opcode,
  input  logic [4:0] alu_op,
  input  logic [4:0] rd,
  input  logic       flush,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       Rwe,
  output logic       br,
  output logic       DMwe,
  output logic       ALUinB,
  output logic       Rwd,
  output logic       j_sig,
  output logic       jr_sig,
  output logic       jal_sig,
  output logic       led_we,
  output logic       cap_sig,
  output logic       illegal,
  output logic       md_start,
  output logic       md_busy,
  output logic       md_abort
);

  // Accept edge counts as the first mul/div cycle and the edge into FULL as the last.
  localparam logic [5:0] MD_LOAD = 6'(MULDIV_CYC - 2);

  logic [1:0] state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic       md_start_q, md_start_d;
  logic       md_abort_q, md_abort_d;

  ctrl_t      dec;
  logic       dec_md;
  logic       capture;

  ctrl_decode_comb #(.CUSTOM_EN(CUSTOM_EN)) u_dec (
    .opcode_i (opcode),
    .alu_op_i (alu_op),
    .rd_i     (rd),
    .ctrl_o   (dec),
    .is_md_o  (dec_md)
  );

  assign in_ready  = (state_q == ST_EMPTY) || ((state_q == ST_FULL) && out_ready);
  assign out_valid = (state_q == ST_FULL);
  assign md_busy   = (state_q == ST_MD);
  assign capture   = in_valid && in_ready && !flush;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ctrl_d     = ctrl_q;
    md_start_d = 1'b0;
    md_abort_d = flush && (state_q == ST_MD);
    if (flush) begin
      state_d = ST_EMPTY;
      cnt_d   = '0;
    end else if (capture) begin
      ctrl_d = dec;
      if (dec_md) begin
        state_d    = ST_MD;
        cnt_d      = MD_LOAD;
        md_start_d = 1'b1;
      end else begin
        state_d = ST_FULL;
      end
    end else begin
      case (state_q)
        ST_EMPTY: ;
        ST_FULL:  if (out_ready) state_d = ST_EMPTY;
        ST_MD: begin
          if (cnt_q == 6'd0) state_d = ST_FULL;
          else               cnt_d   = cnt_q - 6'd1;
        end
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_EMPTY;
      cnt_q      <= '0;
      ctrl_q     <= '0;
      md_start_q <= 1'b0;
      md_abort_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ctrl_q     <= ctrl_d;
      md_start_q <= md_start_d;
      md_abort_q <= md_abort_d;
    end
  end

  assign Rwe      = ctrl_q.rwe;
  assign br       = ctrl_q.br;
  assign DMwe     = ctrl_q.dmwe;
  assign ALUinB   = ctrl_q.aluinb;
  assign Rwd      = ctrl_q.rwd;
  assign j_sig    = ctrl_q.j;
  assign jr_sig   = ctrl_q.jr;
  assign jal_sig  = ctrl_q.jal;
  assign led_we   = ctrl_q.led_we;
  assign cap_sig  = ctrl_q.cap;
  assign illegal  = ctrl_q.illegal;
  assign md_start = md_start_q;
  assign md_abort = md_abort_q;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Bench for ctrl_decode_stage: two instances (custom opcodes on/off) driven
// identically and checked every cycle against a behavioural slot model.
module tb_ctrl_decode_stage;

  localparam int MDC = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [4:0] opcode = '0, alu_op = '0, rd = '0;

  logic [1:0] ir, ov, ms, mb, ma;
  logic [1:0] rwe, br, dmwe, alub, rwd, js, jrs, jals, led, cap, ill;
  logic [10:0] ctl [2];

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ctrl_decode_stage #(.MULDIV_CYC(MDC), .CUSTOM_EN(g == 0 ? 1 : 0)) u_dut (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(ir[g]),
      .opcode(opcode), .alu_op(alu_op), .rd(rd), .flush(flush),
      .out_valid(ov[g]), .out_ready(out_ready),
      .Rwe(rwe[g]), .br(br[g]), .DMwe(dmwe[g]), .ALUinB(alub[g]), .Rwd(rwd[g]),
      .j_sig(js[g]), .jr_sig(jrs[g]), .jal_sig(jals[g]), .led_we(led[g]),
      .cap_sig(cap[g]), .illegal(ill[g]),
      .md_start(ms[g]), .md_busy(mb[g]), .md_abort(ma[g])
    );
    assign ctl[g] = {ill[g], cap[g], led[g], jals[g], jrs[g], js[g],
                     rwd[g], alub[g], dmwe[g], br[g], rwe[g]};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference decode from the instruction table; returns {is_md, ctrl[10:0]}
  // with ctrl bit order {ill,cap,led,jal,jr,j,Rwd,ALUinB,DMwe,br,Rwe}.
  function automatic logic [11:0] ref_dec(input logic [4:0] op, input logic [4:0] aop,
                                          input logic [4:0] r, input bit cen);
    logic [10:0] c;
    bit md, wr;
    c = '0; md = 0; wr = 0;
    if (op >= 5'd9 && op <= 5'd12 && !cen) c[10] = 1'b1;
    else case (op)
      5'd0:  if (aop <= 5'd7) begin wr = 1; md = (aop >= 5'd6); end else c[10] = 1'b1;
      5'd1:  c[5] = 1'b1;
      5'd2, 5'd6, 5'd9, 5'd22: c[1] = 1'b1;
      5'd3:  begin c[7] = 1'b1; c[0] = 1'b1; end
      5'd4:  c[6] = 1'b1;
      5'd5:  begin wr = 1; c[3] = 1'b1; end
      5'd7:  begin c[2] = 1'b1; c[3] = 1'b1; end
      5'd8:  begin wr = 1; c[3] = 1'b1; c[4] = 1'b1; end
      5'd10: wr = 1;
      5'd11: c[8] = 1'b1;
      5'd12: c[9] = 1'b1;
      5'd21: c[0] = 1'b1;
      default: c[10] = 1'b1;
    endcase
    if (wr && r != 5'd0) c[0] = 1'b1;
    return {md, c};
  endfunction

  // Model: one slot, occupied or not, with a remaining-wait count before it is visible.
  bit m_held = 0, m_start = 0, m_abort = 0;
  int m_wait = 0;
  logic [10:0] m_ctl [2] = '{11'd0, 11'd0};
  bit e_ir, e_acc;
  logic [11:0] e_d0, e_d1;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_held = 0; m_wait = 0; m_start = 0; m_abort = 0;
      m_ctl[0] = '0; m_ctl[1] = '0;
    end else begin
      e_ir  = !m_held || (m_wait == 0 && out_ready);
      e_acc = in_valid && e_ir && !flush;
      e_d0  = ref_dec(opcode, alu_op, rd, 1'b1);
      e_d1  = ref_dec(opcode, alu_op, rd, 1'b0);
      m_abort = flush && m_held && (m_wait > 0);
      m_start = e_acc && e_d0[11];
      if (flush) begin
        m_held = 0; m_wait = 0;
      end else if (e_acc) begin
        m_held = 1;
        m_ctl[0] = e_d0[10:0];
        m_ctl[1] = e_d1[10:0];
        m_wait = e_d0[11] ? MDC - 1 : 0;
      end else if (m_held && m_wait == 0 && out_ready) begin
        m_held = 0;
      end else if (m_wait > 0) begin
        m_wait--;
      end
    end
  end

  always @(negedge clock) begin
    for (int k = 0; k < 2; k++)
      chk($sformatf("cycle_u%0d", k),
          {16'd0, ir[k], ov[k], ms[k], mb[k], ma[k], ctl[k]},
          {16'd0, (!m_held || (m_wait == 0 && out_ready)), (m_held && m_wait == 0),
           m_start, (m_held && m_wait > 0), m_abort, m_ctl[k]});
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [4:0] aop, input logic [4:0] r);
    in_valid = 1'b1; opcode = op; alu_op = aop; rd = r;
  endtask

  logic [4:0] ops [15] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
                           5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd21, 5'd22};

  initial begin
    #1 reset_n = 1'b0;
    #1;
    chk("reset_in_ready", ir, 2'b11);
    chk("reset_out_valid", ov, 2'b00);
    chk("reset_ctrl", ctl[0], 0);
    chk("reset_md", {ms, mb, ma}, 0);
    #14 reset_n = 1'b1;

    chk("ref_addi", ref_dec(5'd5, 5'd0, 5'd5, 1'b1), 12'h009);
    chk("ref_lw_r0", ref_dec(5'd8, 5'd0, 5'd0, 1'b1), 12'h018);
    chk("ref_mul", ref_dec(5'd0, 5'd6, 5'd3, 1'b1), 12'h801);
    chk("ref_beq_nocustom", ref_dec(5'd9, 5'd0, 5'd0, 1'b0), 12'h400);
    chk("ref_jal", ref_dec(5'd3, 5'd0, 5'd0, 1'b1), 12'h081);

    out_ready = 1'b1;
    drive(5'd5, 5'd0, 5'd5); step();
    chk("addi_valid", ov[0], 1); chk("addi_ctrl", ctl[0], 11'h009);
    in_valid = 1'b0; step();
    chk("addi_drained", ov[0], 0);

    drive(5'd8, 5'd0, 5'd0); step();
    chk("lw_r0_ctrl", ctl[0], 11'h018);
    in_valid = 1'b0; step();

    drive(5'd0, 5'd6, 5'd3); step();
    chk("mul_start", {ms[0], mb[0], ov[0]}, 3'b110);
    in_valid = 1'b0; step();
    chk("mul_busy2", {ms[0], mb[0], ov[0]}, 3'b010);
    step();
    chk("mul_busy3", {ms[0], mb[0], ov[0], ir[0]}, 4'b0100);
    step();
    chk("mul_done", {mb[0], ov[0]}, 2'b01); chk("mul_ctrl", ctl[0], 11'h001);
    step();

    drive(5'd31, 5'd0, 5'd0); step();
    chk("ill_op", ctl[0], 11'h400);
    drive(5'd0, 5'd8, 5'd2); step();
    chk("ill_alu", ctl[0], 11'h400);
    drive(5'd9, 5'd0, 5'd0); step();
    chk("beq_custom", ctl[0], 11'h002); chk("beq_nocustom", ctl[1], 11'h400);
    in_valid = 1'b0; step();

    drive(5'd7, 5'd0, 5'd0); step();
    chk("sw_ctrl", ctl[0], 11'h00C);
    drive(5'd9, 5'd0, 5'd0); out_ready = 1'b0; step();
    chk("sw_held", {ov[0], ctl[0]}, {1'b1, 11'h00C});
    out_ready = 1'b1; step();
    chk("beq_ctrl", ctl[0], 11'h002);
    drive(5'd3, 5'd0, 5'd0); out_ready = 1'b0; step();
    chk("beq_held", {ov[0], ctl[0]}, {1'b1, 11'h002});
    out_ready = 1'b1; step();
    chk("jal_ctrl", ctl[0], 11'h081);
    in_valid = 1'b0; step();
    chk("b2b_drained", ov[0], 0);

    drive(5'd0, 5'd7, 5'd1); step();
    in_valid = 1'b0; step();
    flush = 1'b1; step();
    chk("flush_md_abort", {ma[0], mb[0], ir[0], ov[0]}, 4'b1010);
    flush = 1'b0; step();
    chk("flush_abort_pulse", ma[0], 0);

    drive(5'd5, 5'd0, 5'd5); flush = 1'b1; step();
    chk("flush_empty", {ov[0], ir[0], mb[0]}, 3'b010);
    flush = 1'b0; in_valid = 1'b0; step();
    chk("flush_empty_after", ov[0], 0);

    drive(5'd0, 5'd6, 5'd3); step();
    in_valid = 1'b0; step();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_md_async", {ir[0], ov[0], mb[0], ms[0], ma[0]}, 5'b10000);
    chk("rst_md_ctrl", ctl[0], 0);
    #2 reset_n = 1'b1;
    step();
    chk("rst_md_no_abort", {ma[0], ir[0], ov[0]}, 3'b010);

    drive(5'd5, 5'd0, 5'd5); step();
    in_valid = 1'b0; out_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_full_async", {ir[0], ov[0], ma[0]}, 3'b100);
    chk("rst_full_ctrl", ctl[0], 0);
    #2 reset_n = 1'b1;
    out_ready = 1'b1; step();

    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) == 0) opcode = 5'($urandom_range(0, 31));
      else opcode = ops[$urandom_range(0, 14)];
      alu_op = 5'($urandom_range(0, 9));
      rd = 5'($urandom_range(0, 3));
      flush = ($urandom_range(0, 29) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 299) == 0) begin
        #2 reset_n = 1'b0;
        #1;
        chk("rand_async_reset", {ir, ov, mb, ms, ma}, 10'b1100000000);
        #2 reset_n = 1'b1;
      end
      step();
    end

    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    step(); step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
